// File: rtl/alu_share_arbiter.sv
// rtl/alu_share_arbiter.sv - round-robin arbiter sharing one combinational ALU between two requesters
//
// Ports:
//   clk, reset                 clock (rising edge), asynchronous active-high reset
//   req0_* / req1_*            request channels: valid/ready handshake, operands a/b,
//                              function code fun, signed flag sign
//   alu_a/alu_b/alu_fun/alu_sign  registered operands to the shared ALU
//   alu_out                    ALU result, combinational from alu_*
//   rsp_valid/rsp_ready        response handshake
//   rsp_id/rsp_data            owner of the result and the registered raw ALU result
//
// Optional build macro ALU_ARB_LOCK_EN adds req0_lock/req1_lock; an accepted
// locked request keeps the grant with its port until it issues an unlocked op.
module alu_share_arbiter #(
   parameter int DW = 32,
   parameter int FW = 6
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          req0_valid,
   output logic          req0_ready,
   input  logic [DW-1:0] req0_a,
   input  logic [DW-1:0] req0_b,
   input  logic [FW-1:0] req0_fun,
   input  logic          req0_sign,
   input  logic          req1_valid,
   output logic          req1_ready,
   input  logic [DW-1:0] req1_a,
   input  logic [DW-1:0] req1_b,
   input  logic [FW-1:0] req1_fun,
   input  logic          req1_sign,
`ifdef ALU_ARB_LOCK_EN
   input  logic          req0_lock,
   input  logic          req1_lock,
`endif
   output logic [DW-1:0] alu_a,
   output logic [DW-1:0] alu_b,
   output logic [FW-1:0] alu_fun,
   output logic          alu_sign,
   input  logic [DW-1:0] alu_out,
   output logic          rsp_valid,
   input  logic          rsp_ready,
   output logic          rsp_id,
   output logic [DW-1:0] rsp_data
);

   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

   state_t state, state_nxt;
   logic   last_grant;
   logic   tag;
   logic   elig0, elig1;
   logic   gnt_valid, gnt_id;
   logic   accept_ok, accept;

`ifdef ALU_ARB_LOCK_EN
   logic   lock_valid, lock_id;
   logic   sel_lock;

   // A held lock masks the non-owner even when the owner has nothing to issue.
   assign elig0    = req0_valid & (~lock_valid | ~lock_id);
   assign elig1    = req1_valid & (~lock_valid |  lock_id);
   assign sel_lock = gnt_id ? req1_lock : req0_lock;
`else
   assign elig0 = req0_valid;
   assign elig1 = req1_valid;
`endif

   assign gnt_valid  = elig0 | elig1;
   // Under contention the port that did not win last time goes next.
   assign gnt_id     = (elig0 & elig1) ? ~last_grant : elig1;

   // A new op may enter while the previous response is being drained.
   assign accept_ok  = (state == IDLE) | ((state == RESP) & rsp_ready);
   assign accept     = accept_ok & gnt_valid;
   assign req0_ready = accept & ~gnt_id;
   assign req1_ready = accept &  gnt_id;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (accept) state_nxt = EXEC;
         EXEC: state_nxt = RESP;
         RESP: if (rsp_ready) state_nxt = accept ? EXEC : IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         alu_a      <= '0;
         alu_b      <= '0;
         alu_fun    <= '0;
         alu_sign   <= 1'b0;
         tag        <= 1'b0;
         last_grant <= 1'b1;
         rsp_valid  <= 1'b0;
         rsp_id     <= 1'b0;
         rsp_data   <= '0;
      end else begin
         if (accept) begin
            alu_a      <= gnt_id ? req1_a    : req0_a;
            alu_b      <= gnt_id ? req1_b    : req0_b;
            alu_fun    <= gnt_id ? req1_fun  : req0_fun;
            alu_sign   <= gnt_id ? req1_sign : req0_sign;
            tag        <= gnt_id;
            last_grant <= gnt_id;
         end
         if (state == EXEC) begin
            rsp_data  <= alu_out;
            rsp_id    <= tag;
            rsp_valid <= 1'b1;
         end else if ((state == RESP) && rsp_ready) begin
            rsp_valid <= 1'b0;
         end
      end
   end

`ifdef ALU_ARB_LOCK_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         lock_valid <= 1'b0;
         lock_id    <= 1'b0;
      end else if (accept) begin
         lock_valid <= sel_lock;
         lock_id    <= gnt_id;
      end
   end
`endif

endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb/tb_alu_share_arbiter.sv - randomized and directed bench for alu_share_arbiter
module tb_alu_share_arbiter;
   localparam int DW = 32;
   localparam int FW = 6;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          req0_valid = 0, req1_valid = 0;
   logic          req0_ready, req1_ready;
   logic [DW-1:0] req0_a = 0, req0_b = 0, req1_a = 0, req1_b = 0;
   logic [FW-1:0] req0_fun = 0, req1_fun = 0;
   logic          req0_sign = 0, req1_sign = 0;
`ifdef ALU_ARB_LOCK_EN
   logic          req0_lock = 0, req1_lock = 0;
`endif
   logic [DW-1:0] alu_a, alu_b, alu_out;
   logic [FW-1:0] alu_fun;
   logic          alu_sign;
   logic          rsp_valid, rsp_id;
   logic          rsp_ready = 0;
   logic [DW-1:0] rsp_data;

   always #5 clk = ~clk;

   alu_share_arbiter #(.DW(DW), .FW(FW)) dut (
      .clk(clk), .reset(reset),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
      .req0_fun(req0_fun), .req0_sign(req0_sign),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
      .req1_fun(req1_fun), .req1_sign(req1_sign),
`ifdef ALU_ARB_LOCK_EN
      .req0_lock(req0_lock), .req1_lock(req1_lock),
`endif
      .alu_a(alu_a), .alu_b(alu_b), .alu_fun(alu_fun), .alu_sign(alu_sign), .alu_out(alu_out),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data)
   );

   // Small team ALU: the shift ops shift b by a[4:0].
   function automatic logic [DW-1:0] alu_fn(input logic [FW-1:0] f, input logic [DW-1:0] a,
                                            input logic [DW-1:0] b, input logic s);
      case (f)
         6'b000000: return a + b;
         6'b000001: return a - b;
         6'b011000: return a & b;
         6'b011110: return a | b;
         6'b010110: return a ^ b;
         6'b100000: return b << a[4:0];
         6'b100001: return b >> a[4:0];
         6'b100011: return s ? DW'($signed(b) >>> a[4:0]) : (b >> a[4:0]);
         default:   return '0;
      endcase
   endfunction

   assign alu_out = alu_fn(alu_fun, alu_a, alu_b, alu_sign);

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference model: one op in flight, its response visible two cycles after accept.
   bit            m_busy;
   int            m_age;
   bit            m_id;
   logic [DW-1:0] m_data;
   bit            m_last;
   logic [DW-1:0] m_alu_a;
   logic [FW-1:0] m_alu_fun;
   bit            m_lock_v, m_lock_id;
   int            acc_count;
   bit            rsp_log[$];

   task automatic model_reset();
      m_busy = 0; m_age = 0; m_id = 0; m_data = '0; m_last = 1;
      m_alu_a = '0; m_alu_fun = '0; m_lock_v = 0; m_lock_id = 0;
   endtask

   task automatic tick();
      bit e0, e1, exp_rv, can, w_valid, w_id, rr, lk;
      logic [DW-1:0] a, b;
      logic [FW-1:0] f;
      logic s;
      @(negedge clk);
      exp_rv = m_busy && (m_age >= 2);
      rr     = rsp_ready;
      can    = !m_busy || (exp_rv && rr);
      e0 = req0_valid; e1 = req1_valid;
      if (m_lock_v) begin
         if (m_lock_id) e0 = 0; else e1 = 0;
      end
      w_valid = e0 | e1;
      w_id    = (e0 && e1) ? !m_last : e1;
      check("req0_ready", req0_ready, can && w_valid && !w_id);
      check("req1_ready", req1_ready, can && w_valid && w_id);
      check("rsp_valid", rsp_valid, exp_rv);
      if (exp_rv) begin
         check("rsp_id", rsp_id, m_id);
         check("rsp_data", rsp_data, m_data);
      end
      check("alu_a", alu_a, m_alu_a);
      check("alu_fun", alu_fun, m_alu_fun);
      a  = w_id ? req1_a : req0_a;
      b  = w_id ? req1_b : req0_b;
      f  = w_id ? req1_fun : req0_fun;
      s  = w_id ? req1_sign : req0_sign;
      lk = 0;
`ifdef ALU_ARB_LOCK_EN
      lk = w_id ? req1_lock : req0_lock;
`endif
      @(posedge clk);
      if (exp_rv && rr) begin
         m_busy = 0;
         rsp_log.push_back(m_id);
      end
      if (m_busy) m_age++;
      if (can && w_valid) begin
         m_busy = 1; m_age = 1; m_id = w_id; m_last = w_id;
         m_data = alu_fn(f, a, b, s);
         m_alu_a = a; m_alu_fun = f;
         m_lock_v = lk; m_lock_id = w_id;
         acc_count++;
      end
      #1;
   endtask

   task automatic do_reset();
      req0_valid = 0; req1_valid = 0; rsp_ready = 0;
      reset = 1;
      #1;
      check("rst_rsp_valid", rsp_valid, 0);
      check("rst_alu_a", alu_a, 0);
      check("rst_alu_fun", alu_fun, 0);
      @(posedge clk); #1;
      check("rst_rsp_data", rsp_data, 0);
      check("rst_rsp_id", rsp_id, 0);
      check("rst_alu_b", alu_b, 0);
      reset = 0;
      model_reset();
   endtask

   task automatic set0(input logic [FW-1:0] f, input logic [DW-1:0] a, input logic [DW-1:0] b, input logic s);
      req0_fun = f; req0_a = a; req0_b = b; req0_sign = s;
   endtask

   task automatic set1(input logic [FW-1:0] f, input logic [DW-1:0] a, input logic [DW-1:0] b, input logic s);
      req1_fun = f; req1_a = a; req1_b = b; req1_sign = s;
   endtask

   logic [FW-1:0] funs [8] = '{6'b000000, 6'b000001, 6'b011000, 6'b011110,
                               6'b010110, 6'b100000, 6'b100001, 6'b100011};

   initial begin
      model_reset();
      @(posedge clk); #1;
      do_reset();

      // Single op: 5 + 7 with backpressure hold.
      set0(6'b000000, 5, 7, 1); req0_valid = 1;
      tick();
      req0_valid = 0;
      check("single_exec_valid", rsp_valid, 0);
      tick();
      check("single_valid", rsp_valid, 1);
      check("single_data", rsp_data, 12);
      check("single_id", rsp_id, 0);
      for (int i = 0; i < 3; i++) begin
         tick();
         check("single_hold", rsp_data, 12);
      end
      rsp_ready = 1;
      tick();
      check("single_done", rsp_valid, 0);

      // Contention after reset: port 0 first, then port 1.
      do_reset();
      set0(6'b000001, 9, 4, 0); set1(6'b011110, 32'hF0, 32'h0F, 0);
      req0_valid = 1; req1_valid = 1; rsp_ready = 1;
      #1;
      check("cont_first_r0", req0_ready, 1);
      check("cont_first_r1", req1_ready, 0);
      tick();
      req0_valid = 0;
      tick();
      check("cont_data0", rsp_data, 5);
      check("cont_id0", rsp_id, 0);
      tick();
      req1_valid = 0;
      tick();
      check("cont_data1", rsp_data, 32'hFF);
      check("cont_id1", rsp_id, 1);
      tick();

      // Fairness: both always valid, six ops with no idle bubble.
      do_reset();
      set0(6'b000000, 1, 2, 0); set1(6'b010110, 3, 5, 0);
      req0_valid = 1; req1_valid = 1; rsp_ready = 1;
      acc_count = 0; rsp_log.delete();
      for (int i = 0; i < 12; i++) tick();
      req0_valid = 0; req1_valid = 0;
      for (int i = 0; i < 2; i++) tick();
      check("fair_accepts", acc_count, 6);
      check("fair_rsps", rsp_log.size(), 6);
      for (int i = 0; i < rsp_log.size() && i < 6; i++)
         check("fair_id", rsp_log[i], 64'(i % 2));

      // Backpressure: req1 waits while the response is held.
      do_reset();
      set0(6'b000000, 3, 4, 0); set1(6'b011000, 32'hFF, 32'h3C, 0);
      req0_valid = 1;
      tick();
      req0_valid = 0; req1_valid = 1;
      tick();
      for (int i = 0; i < 5; i++) begin
         check("bp_data", rsp_data, 7);
         check("bp_id", rsp_id, 0);
         tick();
      end
      rsp_ready = 1;
      #1;
      check("bp_release_r1", req1_ready, 1);
      tick();
      req1_valid = 0;
      tick();
      check("bp_data1", rsp_data, 32'h3C);
      tick();

      // Reset in EXEC drops the op; first contention afterwards goes to port 0.
      do_reset();
      set0(6'b000000, 10, 20, 0); req0_valid = 1;
      tick();
      req0_valid = 0;
      reset = 1;
      #1;
      check("midrst_rsp_valid", rsp_valid, 0);
      check("midrst_alu_a", alu_a, 0);
      check("midrst_alu_b", alu_b, 0);
      @(posedge clk); #1;
      reset = 0;
      model_reset();
      req0_valid = 1; req1_valid = 1; rsp_ready = 1;
      #1;
      check("midrst_grant0", req0_ready, 1);
      tick();
      req0_valid = 0; req1_valid = 0;
      tick(); tick();

`ifdef ALU_ARB_LOCK_EN
      // Lock: port 1 holds the ALU across ops until it issues an unlocked op.
      do_reset();
      set1(6'b100000, 4, 1, 0); req1_lock = 1; req1_valid = 1;
      set0(6'b000000, 1, 1, 0); rsp_ready = 1;
      tick();
      req1_valid = 0; req0_valid = 1;
      tick();
      check("lock_data", rsp_data, 16);
      check("lock_r0_blocked", req0_ready, 0);
      tick(); tick();
      req1_valid = 1; req1_lock = 0;
      tick();
      req1_valid = 0;
      tick();
      #1;
      check("lock_r0_granted", req0_ready, 1);
      tick();
      req0_valid = 0;
      tick(); tick();
`endif

      // Randomized traffic against the model.
      do_reset();
      for (int i = 0; i < 400; i++) begin
         req0_valid = ($urandom_range(0, 9) < 6);
         req1_valid = ($urandom_range(0, 9) < 6);
         rsp_ready  = ($urandom_range(0, 9) < 7);
         set0(funs[$urandom_range(0, 7)], $urandom, $urandom, 1'($urandom));
         set1(funs[$urandom_range(0, 7)], $urandom, $urandom, 1'($urandom));
`ifdef ALU_ARB_LOCK_EN
         req0_lock = ($urandom_range(0, 9) < 2);
         req1_lock = ($urandom_range(0, 9) < 2);
`endif
         tick();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
